alu_serial_ctrl: RTL and testbench



---
 rtl/alu_serial_ctrl_if.sv | 57 +++++
 rtl/alu_serial_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_ctrl_if.sv
// alu_serial_ctrl_if
// Groups the command handshake and the 1-bit ALU slice bus of the
// bit-serial sequencer.
//   master : command source (drives start/cmd_*, receives status/result)
//   slave  : the sequencer itself
//   alu    : the combinational 1-bit ALU slice
// Signals:
//   start, cmd_a, cmd_b, cmd_ainv, cmd_binv, cmd_cin, cmd_op -> command
//   busy, done, err, result, cout, zero, ovf                 <- status
//   slice_a, slice_b, slice_ainv, slice_binv, slice_cin,
//   slice_op                                                  -> slice
//   slice_res, slice_cout                                     <- slice
interface alu_serial_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_ainv;
    logic             cmd_binv;
    logic             cmd_cin;
    logic [1:0]       cmd_op;

    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             ovf;

    logic             slice_a;
    logic             slice_b;
    logic             slice_ainv;
    logic             slice_binv;
    logic             slice_cin;
    logic [1:0]       slice_op;
    logic             slice_res;
    logic             slice_cout;

    modport master (
        output start, cmd_a, cmd_b, cmd_ainv, cmd_binv, cmd_cin, cmd_op,
        input  busy, done, err, result, cout, zero, ovf
    );

    modport slave (
        input  start, cmd_a, cmd_b, cmd_ainv, cmd_binv, cmd_cin, cmd_op,
        output busy, done, err, result, cout, zero, ovf,
        output slice_a, slice_b, slice_ainv, slice_binv, slice_cin, slice_op,
        input  slice_res, slice_cout
    );

    modport alu (
        input  slice_a, slice_b, slice_ainv, slice_binv, slice_cin, slice_op,
        output slice_res, slice_cout
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl
// Bit-serial sequencer: evaluates a WIDTH-bit AND/OR/ADD one bit per clock,
// LSB first, by driving a single combinational 1-bit ALU slice and feeding
// the registered slice carry back as the next carry-in.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : alu_serial_ctrl_if.slave (command handshake + slice bus)
// Parameters:
//   WIDTH  : operand/result width, minimum 2
// Configuration:
//   ALU_SERIAL_FLAGS_EN : when defined, builds the zero/ovf flag logic;
//                         otherwise zero and ovf are tied to 0.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_serial_ctrl_if.slave   bus
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             ainv_q;
    logic             binv_q;
    logic             cin_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             slice_cin_d;
    logic [WIDTH-1:0] result_d;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign result_d = {bus.slice_res, result_q[WIDTH-1:1]};

    // Slice inputs are only live while running; forced to 0 otherwise.
    always_comb begin
        bus.slice_a    = 1'b0;
        bus.slice_b    = 1'b0;
        bus.slice_ainv = 1'b0;
        bus.slice_binv = 1'b0;
        bus.slice_op   = 2'b00;
        slice_cin_d    = (cnt_q == '0) ? cin_q : carry_q;
        bus.slice_cin  = 1'b0;
        if (state_q == RUN) begin
            bus.slice_a    = a_q[cnt_q];
            bus.slice_b    = b_q[cnt_q];
            bus.slice_ainv = ainv_q;
            bus.slice_binv = binv_q;
            bus.slice_op   = op_q;
            bus.slice_cin  = slice_cin_d;
        end
    end

`ifdef ALU_SERIAL_FLAGS_EN
    logic zero_q;
    logic cin_msb_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ainv_q    <= 1'b0;
            binv_q    <= 1'b0;
            cin_q     <= 1'b0;
            op_q      <= 2'b00;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
            zero_q    <= 1'b0;
            cin_msb_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.cmd_op == OP_ILL) begin
                            err_q <= 1'b1;
                        end else begin
                            a_q      <= bus.cmd_a;
                            b_q      <= bus.cmd_b;
                            ainv_q   <= bus.cmd_ainv;
                            binv_q   <= bus.cmd_binv;
                            cin_q    <= bus.cmd_cin;
                            op_q     <= bus.cmd_op;
                            cnt_q    <= '0;
                            result_q <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= bus.slice_cout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_bit) begin
                        cout_q  <= bus.slice_cout;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifdef ALU_SERIAL_FLAGS_EN
                        zero_q    <= (result_d == '0);
                        cin_msb_q <= (op_q == OP_ADD) ? bus.slice_cin : 1'b0;
`endif
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;

`ifdef ALU_SERIAL_FLAGS_EN
    assign bus.zero = zero_q;
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign bus.ovf  = (op_q == OP_ADD) & (cin_msb_q ^ cout_q);
`else
    assign bus.zero = 1'b0;
    assign bus.ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl
// Scoreboard bench for alu_serial_ctrl: WIDTH=8 and WIDTH=2 instances, each
// attached to a behavioural 1-bit ALU slice. Expected responses are queued
// when a command is accepted; monitors pop and compare on every done pulse.
module tb_alu_serial_ctrl;

`ifdef ALU_SERIAL_FLAGS_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    typedef struct {
        logic [7:0]  res;
        logic        cout;
        logic        zero;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;
    int unsigned pass_cnt;
    int unsigned total_cnt;
    exp_t        q8[$];
    exp_t        q2[$];

    alu_serial_ctrl_if #(.WIDTH(8)) bus8 ();
    alu_serial_ctrl_if #(.WIDTH(2)) bus2 ();

    alu_serial_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    alu_serial_ctrl #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Behavioural slice: returns {cout, res}; carry is a full-adder carry.
    function automatic logic [1:0] slice_f(input logic a, input logic b,
                                           input logic ai, input logic bi,
                                           input logic ci, input logic [1:0] op);
        logic x, y, r;
        x = a ^ ai;
        y = b ^ bi;
        case (op)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y ^ ci;
            default: r = 1'b0;
        endcase
        return {(x & y) | (x & ci) | (y & ci), r};
    endfunction

    assign {bus8.slice_cout, bus8.slice_res} = slice_f(bus8.slice_a, bus8.slice_b,
        bus8.slice_ainv, bus8.slice_binv, bus8.slice_cin, bus8.slice_op);
    assign {bus2.slice_cout, bus2.slice_res} = slice_f(bus2.slice_a, bus2.slice_b,
        bus2.slice_ainv, bus2.slice_binv, bus2.slice_cin, bus2.slice_op);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Monitors: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus8.done) begin
            if (q8.size() == 0) begin
                check("w8_spurious_done", bus8.done, 1'b0);
            end else begin
                e = q8.pop_front();
                check("w8_result", bus8.result, e.res);
                check("w8_cout", bus8.cout, e.cout);
                check("w8_zero", bus8.zero, e.zero);
                check("w8_ovf", bus8.ovf, e.ovf);
                check("w8_done_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus2.done) begin
            if (q2.size() == 0) begin
                check("w2_spurious_done", bus2.done, 1'b0);
            end else begin
                e = q2.pop_front();
                check("w2_result", bus2.result, e.res);
                check("w2_cout", bus2.cout, e.cout);
                check("w2_zero", bus2.zero, e.zero);
                check("w2_ovf", bus2.ovf, e.ovf);
                check("w2_done_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one command to the WIDTH=8 instance and wait for its completion.
    // With hold=1, start stays high and operands change during RUN.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic binv, input logic cin, input logic [1:0] op,
                          input logic [7:0] er, input logic ec, input logic ez,
                          input logic eo, input logic hold);
        exp_t        e;
        int unsigned n;
        @(negedge clk);
        n = 0;
        while (bus8.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("w8_idle_timeout", bus8.busy, 1'b0);
        bus8.cmd_a    = a;
        bus8.cmd_b    = b;
        bus8.cmd_ainv = 1'b0;
        bus8.cmd_binv = binv;
        bus8.cmd_cin  = cin;
        bus8.cmd_op   = op;
        bus8.start    = 1'b1;
        @(posedge clk);
        #1;
        e.res  = er;
        e.cout = ec;
        e.zero = ez & FL;
        e.ovf  = eo & FL;
        e.cyc  = cyc + 8;
        q8.push_back(e);
        check("w8_busy_run", bus8.busy, 1'b1);
        if (hold) begin
            bus8.cmd_a  = 8'hFF;
            bus8.cmd_b  = 8'hFF;
            bus8.cmd_op = 2'b10;
        end else begin
            bus8.start = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus8.done && n < 30);
        if (!bus8.done) check("w8_done_timeout", bus8.done, 1'b1);
        bus8.start = 1'b0;
        @(negedge clk);
        check("w8_done_pulse", bus8.done, 1'b0);
        check("w8_busy_fall", bus8.busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        exp_t        e;
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.cmd_a = '0; bus8.cmd_b = '0; bus8.cmd_ainv = 1'b0;
        bus8.cmd_binv = 1'b0; bus8.cmd_cin = 1'b0; bus8.cmd_op = 2'b00;
        bus2.start = 1'b0; bus2.cmd_a = '0; bus2.cmd_b = '0; bus2.cmd_ainv = 1'b0;
        bus2.cmd_binv = 1'b0; bus2.cmd_cin = 1'b0; bus2.cmd_op = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus8.busy, 1'b0);
        check("rst_done", bus8.done, 1'b0);
        check("rst_err", bus8.err, 1'b0);
        check("rst_result", bus8.result, 8'h00);
        check("rst_cout", bus8.cout, 1'b0);
        check("rst_slice_op", bus8.slice_op, 2'b00);
        check("rst_w2_result", bus2.result, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // AND, ADD wrap, SUB, signed overflow
        issue8(8'hA5, 8'h3C, 1'b0, 1'b0, 2'b00, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0);
        issue8(8'hFF, 8'h01, 1'b0, 1'b0, 2'b10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        issue8(8'h05, 8'h07, 1'b1, 1'b1, 2'b10, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        issue8(8'h7F, 8'h01, 1'b0, 1'b0, 2'b10, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);

        // start held high through RUN with different operands: first cmd only
        issue8(8'h12, 8'h34, 1'b0, 1'b0, 2'b01, 8'h36, 1'b0, 1'b0, 1'b0, 1'b1);

        // Illegal op in IDLE: err pulse, no busy, result unchanged
        bus8.cmd_a  = 8'h99;
        bus8.cmd_b  = 8'h66;
        bus8.cmd_op = 2'b11;
        bus8.start  = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        check("ill_err", bus8.err, 1'b1);
        check("ill_busy", bus8.busy, 1'b0);
        @(posedge clk);
        #1;
        check("ill_err_pulse", bus8.err, 1'b0);
        check("ill_result_held", bus8.result, 8'h36);
        check("ill_busy_after", bus8.busy, 1'b0);

        // Reset during RUN bit 4: partial result discarded, no done
        @(negedge clk);
        bus8.cmd_a  = 8'h55;
        bus8.cmd_b  = 8'h33;
        bus8.cmd_op = 2'b10;
        bus8.start  = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_slice_a_bit4", bus8.slice_a, 1'b1);
        check("mid_slice_b_bit4", bus8.slice_b, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_busy", bus8.busy, 1'b0);
        check("mrst_done", bus8.done, 1'b0);
        check("mrst_err", bus8.err, 1'b0);
        check("mrst_result", bus8.result, 8'h00);
        check("mrst_cout", bus8.cout, 1'b0);
        check("mrst_zero", bus8.zero, 1'b0);
        check("mrst_ovf", bus8.ovf, 1'b0);
        check("mrst_slice_a", bus8.slice_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("mrst_still_idle", bus8.busy, 1'b0);
        issue8(8'h0F, 8'h0F, 1'b0, 1'b0, 2'b10, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b0);

        // WIDTH=2 instance: 3 + 1 wraps to 0 with carry out
        @(negedge clk);
        bus2.cmd_a  = 2'b11;
        bus2.cmd_b  = 2'b01;
        bus2.cmd_op = 2'b10;
        bus2.start  = 1'b1;
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        e.res  = 8'h00;
        e.cout = 1'b1;
        e.zero = FL;
        e.ovf  = 1'b0;
        e.cyc  = cyc + 2;
        q2.push_back(e);
        check("w2_busy_run", bus2.busy, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus2.done && n < 20);
        if (!bus2.done) check("w2_done_timeout", bus2.done, 1'b1);
        @(negedge clk);
        check("w2_done_pulse", bus2.done, 1'b0);

        repeat (4) @(negedge clk);
        check("w8_sb_empty", q8.size(), 0);
        check("w2_sb_empty", q2.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
